// File: rtl/gray_count_decoder.sv
// Gray-coded count receiver: decodes samples to binary, checks +1 sequencing,
// tracks lock state and keeps a saturating sequence-error count.
module gray_count_decoder #(
    parameter int WIDTH     = 4,
    parameter int SYNC_LEN  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_vld,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_vld,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int RUN_W = $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               r_state;
    logic [RUN_W-1:0]     r_run;
    logic [WIDTH-1:0]     r_last_bin;

    logic [WIDTH-1:0]     w_bin;
    logic [RUN_W-1:0]     w_run_inc;
    logic                 w_step_ok;
    logic                 w_err;
    logic                 w_wrap;

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign w_bin[i] = ^gray_in[WIDTH-1:i];
    end

    assign w_step_ok = (w_bin == r_last_bin + WIDTH'(1));
    assign w_run_inc = r_run + RUN_W'(1);
    assign w_err     = gray_vld && (r_state == LOCKED) && !w_step_ok;
    assign w_wrap    = gray_vld && (r_state == LOCKED) && w_step_ok && (&r_last_bin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_run      <= '0;
            r_last_bin <= '0;
            bin_out    <= '0;
            bin_vld    <= 1'b0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            bin_vld    <= gray_vld;
            err_pulse  <= w_err;
            wrap_pulse <= w_wrap;
            if (gray_vld) begin
                bin_out    <= w_bin;
                r_last_bin <= w_bin;
                case (r_state)
                    IDLE: begin
                        r_state <= SYNC;
                        r_run   <= '0;
                        locked  <= 1'b0;
                    end
                    SYNC: begin
                        if (!w_step_ok) begin
                            r_run <= '0;
                        end else if (w_run_inc == RUN_W'(SYNC_LEN)) begin
                            r_state <= LOCKED;
                            r_run   <= '0;
                            locked  <= 1'b1;
                        end else begin
                            r_run <= w_run_inc;
                        end
                    end
                    LOCKED: begin
                        if (!w_step_ok) begin
                            r_state <= SYNC;
                            r_run   <= '0;
                            locked  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_run   <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A clear that coincides with an error still records that error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= ERR_CNT_W'(w_err);
        end else if (w_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed and randomized check of gray_count_decoder against a sequence-level model.
module tb_gray_count_decoder;

    localparam int W    = 4;
    localparam int SL   = 2;
    localparam int ECW  = 2;
    localparam int MODV = 1 << W;
    localparam int EMAX = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [W-1:0]   gray_in = '0;
    logic           gray_vld = 1'b0;
    logic           clr_err = 1'b0;
    logic [W-1:0]   bin_out;
    logic           bin_vld;
    logic           locked;
    logic           err_pulse;
    logic           wrap_pulse;
    logic [ECW-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    // model: 0 idle, 1 sync, 2 locked
    int m_state, m_run, m_last, m_cnt;
    int e_bin, e_vld, e_lock, e_err, e_wrap;

    gray_count_decoder #(.WIDTH(W), .SYNC_LEN(SL), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_vld(gray_vld),
        .clr_err(clr_err), .bin_out(bin_out), .bin_vld(bin_vld), .locked(locked),
        .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bin_out"},    32'(bin_out),    32'(e_bin));
        chk({tag, ".bin_vld"},    32'(bin_vld),    32'(e_vld));
        chk({tag, ".locked"},     32'(locked),     32'(e_lock));
        chk({tag, ".err_pulse"},  32'(err_pulse),  32'(e_err));
        chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(e_wrap));
        chk({tag, ".err_cnt"},    32'(err_cnt),    32'(m_cnt));
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_last = 0; m_cnt = 0;
        e_bin = 0; e_vld = 0; e_lock = 0; e_err = 0; e_wrap = 0;
    endtask

    // Drive one cycle with binary value b (sent Gray-encoded), update model, check.
    task automatic step(input string tag, input bit v, input int b, input bit clr);
        int bm;
        bit ok;
        bm       = b % MODV;
        gray_vld = v;
        gray_in  = W'(bm ^ (bm >> 1));
        clr_err  = clr;
        @(posedge clk);
        e_err = 0; e_wrap = 0; e_vld = 0;
        if (v) begin
            e_vld = 1;
            e_bin = bm;
            ok = (bm == (m_last + 1) % MODV);
            if (m_state == 0) begin
                m_state = 1; m_run = 0;
            end else if (m_state == 1) begin
                if (ok) begin
                    m_run++;
                    if (m_run >= SL) m_state = 2;
                end else m_run = 0;
            end else begin
                if (!ok) begin
                    e_err = 1; m_state = 1; m_run = 0;
                end else if (m_last == MODV - 1) e_wrap = 1;
            end
            m_last = bm;
        end
        if (clr) m_cnt = e_err;
        else if (e_err && m_cnt < EMAX) m_cnt++;
        e_lock = (m_state == 2);
        #1;
        check_all(tag);
    endtask

    initial begin
        int n;
        model_reset();
        // 1: reset held, then released with no valid samples
        repeat (3) @(posedge clk);
        #1 check_all("rst_hold");
        reset = 1'b0;
        repeat (3) step("idle", 0, 0, 0);

        // 2: 0,1,2 -> locked after third edge
        step("run0", 1, 0, 0);
        step("run1", 1, 1, 0);
        step("run2", 1, 2, 0);
        chk("lock_after_3", 32'(locked), 32'd1);

        // 3: climb to 15 and wrap to 0
        for (int b = 3; b <= 15; b++) step("climb", 1, b, 0);
        step("wrap", 1, 0, 0);
        chk("wrap_seen", 32'(wrap_pulse), 32'd1);
        step("post_wrap", 1, 1, 0);

        // 4: locked at 3, jump to 5 -> error, then 6,7 relock
        step("to2", 1, 2, 0);
        step("to3", 1, 3, 0);
        step("jump5", 1, 5, 0);
        chk("jump_err_cnt", 32'(err_cnt), 32'd1);
        step("re6", 1, 6, 0);
        step("re7", 1, 7, 0);

        // 5: more errors (incl. a repeated value) until saturation, then clear with error
        n = m_last;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) step("repeat_err", 1, n, 0);
            else begin
                n = n + 2;
                step("jump_err", 1, n, 0);
            end
            step("relock_a", 1, n + 1, 0);
            step("relock_b", 1, n + 2, 0);
            n = n + 2;
        end
        chk("sat_cnt", 32'(err_cnt), 32'(EMAX));
        step("clr_with_err", 1, n + 5, 1);
        chk("clr_err_is_1", 32'(err_cnt), 32'd1);
        step("clr_plain", 0, 0, 1);

        // 6: relock, then gaps of invalid cycles between +1 samples
        n = n + 5;
        step("g0", 1, n + 1, 0);
        step("g1", 1, n + 2, 0);
        for (int k = 3; k < 9; k++) begin
            step("gap", 0, 0, 0);
            step("gap", 0, 0, 0);
            step("gap_smp", 1, n + k, 0);
        end

        // asynchronous reset in the middle of a cycle
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        step("post_rst0", 1, 9, 0);
        step("post_rst1", 1, 10, 0);
        chk("not_yet_locked", 32'(locked), 32'd0);
        step("post_rst2", 1, 11, 0);
        chk("relock_3", 32'(locked), 32'd1);

        // randomized stream: mostly +1 steps, occasional jumps, gaps and clears
        for (int k = 0; k < 400; k++) begin
            int r, b;
            r = int'($urandom_range(0, 99));
            b = (r < 80) ? m_last + 1 : int'($urandom_range(0, MODV - 1));
            step("rand", $urandom_range(0, 3) != 0, b, $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
